// File: rtl/mc_main_control_if.sv
// Control bus between the multi-cycle main control unit and the MIPS datapath.
// The datapath (master) supplies the opcode; the control unit (slave) drives
// every datapath enable/select plus debug state and status flags.
interface mc_main_control_if;
    logic [0:5] opcode;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [0:1] alusrcb;
    logic [0:1] pcsource;
    logic [0:1] aluop;
    logic [0:3] state;
    logic       retire;
    logic       illegal;

    modport master (
        output opcode,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop, state, retire, illegal
    );

    modport slave (
        input  opcode,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop, state, retire, illegal
    );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control unit. A Moore FSM walks each instruction
// through fetch/decode/execute/memory/writeback; all datapath controls are
// decodes of the state register, forced low while reset is held.
module mc_main_control (
    input  logic                clk,
    input  logic                rst,
    mc_main_control_if.slave    bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    stateT state_q;
    stateT state_d;

    // State register: reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the opcode is only consulted in DECODE and MEMADR,
    // and unused codes 12-15 fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode of the current state; everything except the debug state
    // is held at zero during reset so no fetch or write can occur.
    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regdst      = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.pcsource    = 2'b00;
        bus.aluop       = 2'b00;
        bus.retire      = 1'b0;
        bus.illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.memread = 1'b1;
                    bus.irwrite = 1'b1;
                    bus.pcwrite = 1'b1;
                    bus.alusrcb = 2'b01;
                end
                S_DECODE: begin
                    bus.alusrcb = 2'b11;
                    case (bus.opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI:
                            bus.illegal = 1'b0;
                        default:
                            bus.illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    bus.memread = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                    bus.retire   = 1'b1;
                end
                S_MEMWR: begin
                    bus.memwrite = 1'b1;
                    bus.iord     = 1'b1;
                    bus.retire   = 1'b1;
                end
                S_EXEC: begin
                    bus.alusrca = 1'b1;
                    bus.aluop   = 2'b10;
                end
                S_ALUWB: begin
                    bus.regwrite = 1'b1;
                    bus.regdst   = 1'b1;
                    bus.retire   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrca     = 1'b1;
                    bus.aluop       = 2'b01;
                    bus.pcwritecond = 1'b1;
                    bus.pcsource    = 2'b01;
                    bus.retire      = 1'b1;
                end
                S_JUMP: begin
                    bus.pcwrite  = 1'b1;
                    bus.pcsource = 2'b10;
                    bus.retire   = 1'b1;
                end
                S_ADDIEX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    bus.regwrite = 1'b1;
                    bus.retire   = 1'b1;
                end
                default: begin
                    bus.retire = 1'b0;
                end
            endcase
        end
    end

    // Debug view of the current state code.
    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for the multi-cycle main control unit: directed
// instructions, reset aborts, then a randomized instruction stream, all
// compared against a per-instruction state-sequence and output-table model.
module tb_mc_main_control;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mc_main_control_if bus();

    mc_main_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic isLegal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    endfunction

    // Packs the observed controls in a fixed order for whole-word comparison.
    function automatic logic [17:0] getOuts();
        return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                bus.alusrcb, bus.pcsource, bus.aluop, bus.retire, bus.illegal};
    endfunction

    // Reference output table per state code, packed in the getOuts order.
    function automatic logic [17:0] expOut(input int st, input logic [5:0] op, input logic r);
        logic       pw, pwc, iord, mr, mw, irw, mtr, rd, rw, asa, ret, ill;
        logic [1:0] asb, pcs, aop;
        {pw, pwc, iord, mr, mw, irw, mtr, rd, rw, asa, ret, ill} = '0;
        asb = 2'b00;
        pcs = 2'b00;
        aop = 2'b00;
        if (!r) begin
            case (st)
                0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
                1:  begin asb = 2'b11; ill = !isLegal(op); end
                2:  begin asa = 1; asb = 2'b10; end
                3:  begin mr = 1; iord = 1; end
                4:  begin rw = 1; mtr = 1; ret = 1; end
                5:  begin mw = 1; iord = 1; ret = 1; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rw = 1; rd = 1; ret = 1; end
                8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; ret = 1; end
                9:  begin pw = 1; pcs = 2'b10; ret = 1; end
                10: begin asa = 1; asb = 2'b10; end
                11: begin rw = 1; ret = 1; end
                default: ret = 0;
            endcase
        end
        return {pw, pwc, iord, mr, mw, irw, mtr, rd, rw, asa, asb, pcs, aop, ret, ill};
    endfunction

    // Runs one instruction from FETCH, checking every cycle; optionally
    // asserts reset at sequence index abortIdx and holds it for holdCycles.
    task automatic applyStimulus(input logic [5:0] op, input int abortIdx, input int holdCycles);
        int seq[$];
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 10, 11};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
            default:   seq = '{0, 1};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == 1 || seq[i] == 2) begin
                bus.opcode = op;
            end else begin
                bus.opcode = 6'($urandom);
            end
            #1;
            checkOutput("state", 32'(bus.state), 32'(seq[i]));
            checkOutput("outs", 32'(getOuts()), 32'(expOut(seq[i], op, 1'b0)));
            checkOutput("memExcl", 32'(bus.memread & bus.memwrite), 32'd0);
            checkOutput("aluopNot11", 32'(bus.aluop == 2'b11), 32'd0);
            if (i == abortIdx) begin
                rst = 1'b1;
                #1;
                checkOutput("rstOuts", 32'(getOuts()), 32'd0);
                for (int h = 0; h < holdCycles; h++) begin
                    @(posedge clk);
                    #1;
                    bus.opcode = 6'($urandom);
                    #1;
                    checkOutput("rstState", 32'(bus.state), 32'd0);
                    checkOutput("rstHoldOuts", 32'(getOuts()), 32'd0);
                end
                rst = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.opcode = 6'b000000;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000010, 6'b001000, 6'b111111};

        // Reset held three cycles: state 0, every other output low.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            bus.opcode = 6'($urandom);
            #1;
            checkOutput("initState", 32'(bus.state), 32'd0);
            checkOutput("initOuts", 32'(getOuts()), 32'd0);
        end
        rst = 1'b0;

        // Directed: lw, R-type, sw, beq, j, addi, illegal.
        applyStimulus(6'b100011, -1, 0);
        applyStimulus(6'b000000, -1, 0);
        applyStimulus(6'b101011, -1, 0);
        applyStimulus(6'b000100, -1, 0);
        applyStimulus(6'b000010, -1, 0);
        applyStimulus(6'b001000, -1, 0);
        applyStimulus(6'b111111, -1, 0);

        // Reset in MEMWR (sw index 3) and in ALUWB (R-type index 3).
        applyStimulus(6'b101011, 3, 3);
        applyStimulus(6'b000000, 3, 1);
        applyStimulus(6'b100011, -1, 0);

        // Randomized stream with occasional mid-instruction resets.
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            int         pick;
            int         abortIdx;
            pick = int'($urandom_range(0, 7));
            op   = (pick == 7) ? 6'($urandom) : ops[pick];
            abortIdx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            applyStimulus(op, abortIdx, int'($urandom_range(1, 3)));
        end

        #1;
        checkOutput("finalState", 32'(bus.state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable and mux select. It produces the 2-bit `aluop` consumed directly by the ALU control stage, which combines `aluop` with the funct field to select the ALU operation. It is a Moore FSM, so all outputs are pure decodes of the state register.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  [0:5]  instruction-register bits 31:26; stable from end of FETCH until next FETCH.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`, `memtoreg`, `regdst`, `regwrite`, `alusrca`  out  1 each  datapath enables/selects.
- `alusrcb`  out  [0:1]  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pcsource`  out  [0:1]  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target.
- `aluop`  out  [0:1]  to ALU control: 00 add, 01 subtract, 10 use funct. 11 is never driven.
- `state`  out  [0:3]  current state code, for debug/verification.
- `retire`  out  1  high in the last cycle of every legal instruction.
- `illegal`  out  1  high in DECODE when the opcode is unsupported.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable and return to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE on opcode: 100011/101011→MEMADR; 000000→EXEC; 000100→BRANCH; 000010→JUMP; 001000→ADDIEX; any other→FETCH with `illegal`=1.
  - MEMADR→MEMRD if lw, →MEMWR if sw.
  - MEMRD→MEMWB.
  - EXEC→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB→FETCH.
- Outputs not listed for a state are 0:
  - FETCH: memread, irwrite, pcwrite; alusrcb=01; aluop=00; pcsource=00.
  - DECODE: alusrcb=11; aluop=00 (branch target precompute).
  - MEMADR: alusrca=1; alusrcb=10; aluop=00.
  - MEMRD: memread, iord.
  - MEMWB: regwrite, memtoreg; regdst=0.
  - MEMWR: memwrite, iord.
  - EXEC: alusrca=1; alusrcb=00; aluop=10.
  - ALUWB: regwrite, regdst; memtoreg=0.
  - BRANCH: alusrca=1; alusrcb=00; aluop=01; pcwritecond; pcsource=01.
  - JUMP: pcwrite; pcsource=10.
  - ADDIEX: alusrca=1; alusrcb=10; aluop=00.
  - ADDIWB: regwrite; regdst=0; memtoreg=0.
- `retire` is high in MEMWB, MEMWR, ALUWB, BRANCH, JUMP and ADDIWB.
- `opcode` is sampled only in DECODE and MEMADR. Changes in other states have no effect.

## Timing
- Reset: on a rising edge with `rst`=1, state←FETCH. While `rst`=1, every output except `state` is forced to 0, so there are no writes or fetches during reset. `state` reads 0 after the first reset edge.
- Reset mid-instruction aborts the instruction with no further writes. The first cycle after `rst` falls is FETCH.
- Cycle counts from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `aluop` is valid for the whole state cycle and changes only at clock edges, so the ALU control output settles within the same cycle.
- `pcwritecond` is gated with ALU zero outside this block. This block asserts it unconditionally in BRANCH.
- Exactly one of {FETCH, DECODE, …} is active at any time. `memread` and `memwrite` are never both 1.

## Test plan
- Reset: hold `rst`=1 for 3 cycles in any state → all outputs 0; release → `state`=0, memread=irwrite=pcwrite=1, aluop=00, alusrcb=01.
- lw (opcode 100011): state sequence 0,1,2,3,4,0; `retire` only in state 4; regwrite=memtoreg=1, regdst=0 in state 4.
- R-type (000000) then sw (101011): sequence 0,1,6,7,0,1,2,5,0; aluop=10 in state 6; memwrite=iord=1 in state 5.
- beq (000100) and j (000010): beq gives 0,1,8,0 with aluop=01, pcsource=01, pcwritecond=1; j gives 0,1,9,0 with pcwrite=1, pcsource=10.
- addi (001000) and illegal (111111): addi gives 0,1,10,11,0 with aluop=00, alusrcb=10 in state 10; illegal gives 0,1,0 with `illegal`=1 and no regwrite/memwrite.
- Reset asserted in MEMWR and in ALUWB → memwrite/regwrite drop to 0 in that same cycle; the next state is FETCH; aluop is never 11 across a randomized opcode run.
